// File: rtl/arch_defs_pkg.sv
`default_nettype none
// ============================================================================
// Module  : arch_defs_pkg
// Brief   : Shared loader state encoding and frame constants.
// Revision: 1.0 - initial release
// ============================================================================
package arch_defs_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_DATA  = 3'd2,
        ST_CHK   = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } loader_state_t;

    localparam logic [7:0] LOADER_MAGIC = 8'hA5;

endpackage
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module  : prog_loader
// Brief   : Byte-stream program loader: parses MAGIC/ADDR/LEN/DATA/CHK frames,
//           writes program memory and holds the CPU until a good frame lands.
// Revision: 1.0 - initial release
// ============================================================================
module prog_loader #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);
    import arch_defs_pkg::*;

    loader_state_t         state;
    logic [1:0]            hdr_idx;
    logic [7:0]            addr_hi;
    logic [7:0]            len_hi;
    logic [15:0]           remaining;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [7:0]            sum;

    logic       accept;
    logic [7:0] byte_in;

    // The loader never back-pressures; it only refuses bytes while in reset.
    assign rx_ready = reset;
    assign accept   = rx_valid && rx_ready;
    assign byte_in  = rx_data[7:0];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            hdr_idx   <= 2'd0;
            addr_hi   <= 8'd0;
            len_hi    <= 8'd0;
            remaining <= 16'd0;
            wr_addr   <= '0;
            sum       <= 8'd0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_hold  <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            if (accept) begin
                case (state)
                    ST_IDLE, ST_DONE, ST_ERROR: begin
                        if (byte_in == LOADER_MAGIC) begin
                            state    <= ST_HDR;
                            hdr_idx  <= 2'd0;
                            sum      <= 8'd0;
                            busy     <= 1'b1;
                            done     <= 1'b0;
                            error    <= 1'b0;
                            cpu_hold <= 1'b1;
                        end
                    end
                    ST_HDR: begin
                        sum     <= sum + byte_in;
                        hdr_idx <= hdr_idx + 2'd1;
                        case (hdr_idx)
                            2'd0:    addr_hi <= byte_in;
                            2'd1:    wr_addr <= ADDR_WIDTH'({addr_hi, byte_in});
                            2'd2:    len_hi  <= byte_in;
                            default: begin
                                remaining <= {len_hi, byte_in};
                                state     <= ({len_hi, byte_in} == 16'd0) ? ST_CHK : ST_DATA;
                            end
                        endcase
                    end
                    ST_DATA: begin
                        sum       <= sum + byte_in;
                        mem_we    <= 1'b1;
                        mem_addr  <= wr_addr;
                        mem_wdata <= rx_data;
                        wr_addr   <= wr_addr + ADDR_WIDTH'(1);
                        remaining <= remaining - 16'd1;
                        if (remaining == 16'd1) begin
                            state <= ST_CHK;
                        end
                    end
                    ST_CHK: begin
                        busy <= 1'b0;
                        // Sum covers every byte after MAGIC, CHK included.
                        if (8'(sum + byte_in) == 8'd0) begin
                            state    <= ST_DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= ST_ERROR;
                            error <= 1'b1;
                        end
                    end
                    default: begin
                        state    <= ST_IDLE;
                        busy     <= 1'b0;
                        done     <= 1'b0;
                        error    <= 1'b0;
                        cpu_hold <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire
